bram_port_arbiter: RTL and testbench

- Shares one single-port bram instance (1-cycle registered read) between two requesters.
  - Port A: AXI-lite register side.
  - Port B: waveform/streaming engine.
- Accepts at most one command per cycle, issues it on registered BRAM control outputs, and steers the read data back to the owning requester with a valid pulse.
- Supports round-robin or A-priority with anti-starvation, plus a halt/idle handshake for safe reconfiguration.

---
 rtl/bram_port_arbiter_if.sv | 57 +++++
 rtl/bram_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_port_arbiter_if.sv
// Bundle of the requester A/B command-response channels and the BRAM control
// channel shared by bram_port_arbiter.
//   slave  : arbiter view (takes commands from A/B, drives the BRAM controls)
//   master : environment view (requesters plus the BRAM instance)
// Per requester x in {a, b}:
//   x_valid/x_ready      command handshake; accepted when both are high
//   x_we/x_addr/x_wdata  command payload, where we = 1 means write
//   x_rvalid/x_rdata     read response, a single-cycle pulse with no backpressure
// BRAM side:
//   bram_wr_en/bram_rd_en/bram_addr/bram_wr_data  registered controls
//   bram_rd_data                                  valid 1 cycle after bram_rd_en
interface bram_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
);

  logic                  a_valid;
  logic                  a_ready;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_valid;
  logic                  b_ready;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  logic                  bram_wr_en;
  logic                  bram_rd_en;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_wr_data;
  logic [DATA_WIDTH-1:0] bram_rd_data;

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata,
    output a_ready, a_rvalid, a_rdata,
    input  b_valid, b_we, b_addr, b_wdata,
    output b_ready, b_rvalid, b_rdata,
    output bram_wr_en, bram_rd_en, bram_addr, bram_wr_data,
    input  bram_rd_data
  );

  modport master (
    output a_valid, a_we, a_addr, a_wdata,
    input  a_ready, a_rvalid, a_rdata,
    output b_valid, b_we, b_addr, b_wdata,
    input  b_ready, b_rvalid, b_rdata,
    input  bram_wr_en, bram_rd_en, bram_addr, bram_wr_data,
    output bram_rd_data
  );

endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM (1-cycle registered read) between two requesters:
// A (register/AXI-lite side) and B (streaming engine). The arbiter accepts at most
// one command per cycle, issues it on registered BRAM controls in the next cycle,
// and returns read data to the owning requester one cycle after that.
//
// Ports:
//   clk     system clock
//   rst     asynchronous active-low reset
//   halt    blocks new grants while high; in-flight commands still complete
//   idle    high when halt is high and no command is in flight
//   bus_io  requester A/B command/response channels plus the BRAM control channel
//
// Parameters:
//   PRIORITY_MODE  0 = round-robin, 1 = fixed priority to A with anti-starvation
//   STARVE_LIMIT   1..255; A grants taken while B waits before B is forced through
module bram_port_arbiter #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 10,
  parameter int unsigned PRIORITY_MODE = 0,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt,
  output logic               idle,
  bram_port_arbiter_if.slave bus_io
);

  typedef enum logic {
    OwnA = 1'b0,
    OwnB = 1'b1
  } owner_e;

  // Grant
  logic grant_a;
  logic grant_b;
  logic accept;
  logic force_b;

  // Selected command
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Arbitration state
  owner_e     rr_ptr_q, rr_ptr_d;
  logic [7:0] starve_q, starve_d;

  // Issue stage (BRAM controls and the owner tag of the command)
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  owner_e                owner_q, owner_d;

  // Return stage
  logic                  a_rvalid_q, a_rvalid_d;
  logic                  b_rvalid_q, b_rvalid_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;

  // Once starve_q reaches the limit, B wins the next contended cycle.
  assign force_b = (PRIORITY_MODE != 0) && (starve_q >= 8'(STARVE_LIMIT));

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    // Reset is folded in so that ready stays low while the block is held in reset.
    if (rst && !halt) begin
      if (bus_io.a_valid && bus_io.b_valid) begin
        if (PRIORITY_MODE == 0) begin
          if (rr_ptr_q == OwnA) begin
            grant_a = 1'b1;
          end else begin
            grant_b = 1'b1;
          end
        end else if (force_b) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b1;
        end
      end else begin
        grant_a = bus_io.a_valid;
        grant_b = bus_io.b_valid;
      end
    end
  end

  assign accept = grant_a | grant_b;

  always_comb begin
    if (grant_b) begin
      sel_we    = bus_io.b_we;
      sel_addr  = bus_io.b_addr;
      sel_wdata = bus_io.b_wdata;
    end else begin
      sel_we    = bus_io.a_we;
      sel_addr  = bus_io.a_addr;
      sel_wdata = bus_io.a_wdata;
    end
  end

  // Arbitration next state
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_a) begin
      rr_ptr_d = OwnB;
    end else if (grant_b) begin
      rr_ptr_d = OwnA;
    end

    starve_d = starve_q;
    if (PRIORITY_MODE == 0 || !bus_io.b_valid || grant_b) begin
      starve_d = 8'd0;
    end else if (grant_a && starve_q != 8'hFF) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // Issue and return next state
  always_comb begin
    wr_en_d = accept & sel_we;
    rd_en_d = accept & ~sel_we;
    addr_d  = accept ? sel_addr : addr_q;
    wdata_d = accept ? sel_wdata : wdata_q;
    owner_d = accept ? (grant_b ? OwnB : OwnA) : owner_q;

    // The BRAM read launched by rd_en_q produces its data in the next cycle,
    // which is the cycle the owner's rvalid is high.
    a_rvalid_d = rd_en_q && (owner_q == OwnA);
    b_rvalid_d = rd_en_q && (owner_q == OwnB);

    // Hold registers capture the returned word at the end of its rvalid cycle.
    a_rdata_d = a_rvalid_q ? bus_io.bram_rd_data : a_rdata_q;
    b_rdata_d = b_rvalid_q ? bus_io.bram_rd_data : b_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_q   <= OwnA;
      starve_q   <= 8'd0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      owner_q    <= OwnA;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      starve_q   <= starve_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      owner_q    <= owner_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  assign bus_io.a_ready      = grant_a;
  assign bus_io.b_ready      = grant_b;
  assign bus_io.bram_wr_en   = wr_en_q;
  assign bus_io.bram_rd_en   = rd_en_q;
  assign bus_io.bram_addr    = addr_q;
  assign bus_io.bram_wr_data = wdata_q;
  assign bus_io.a_rvalid     = a_rvalid_q;
  assign bus_io.b_rvalid     = b_rvalid_q;

  // During the rvalid cycle the BRAM output is forwarded directly. This keeps the
  // accept-to-rvalid latency at 2 cycles, and the hold register keeps the word
  // afterwards.
  assign bus_io.a_rdata = a_rvalid_q ? bus_io.bram_rd_data : a_rdata_q;
  assign bus_io.b_rdata = b_rvalid_q ? bus_io.bram_rd_data : b_rdata_q;

  // The owner tag travels with the issue stage, so an empty issue stage means
  // nothing is left in flight. idle is forced low while in reset.
  assign idle = halt & rst & ~(wr_en_q | rd_en_q);

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halt;
  logic rr_idle;
  logic fp_idle;

  logic       drv_a_valid, drv_a_we, drv_b_valid, drv_b_we;
  logic [9:0] drv_a_addr, drv_b_addr;
  logic [7:0] drv_a_wdata, drv_b_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) rr_if ();
  bram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) fp_if ();

  assign rr_if.a_valid = drv_a_valid;
  assign rr_if.a_we    = drv_a_we;
  assign rr_if.a_addr  = drv_a_addr;
  assign rr_if.a_wdata = drv_a_wdata;
  assign rr_if.b_valid = drv_b_valid;
  assign rr_if.b_we    = drv_b_we;
  assign rr_if.b_addr  = drv_b_addr;
  assign rr_if.b_wdata = drv_b_wdata;
  assign fp_if.a_valid = drv_a_valid;
  assign fp_if.a_we    = drv_a_we;
  assign fp_if.a_addr  = drv_a_addr;
  assign fp_if.a_wdata = drv_a_wdata;
  assign fp_if.b_valid = drv_b_valid;
  assign fp_if.b_we    = drv_b_we;
  assign fp_if.b_addr  = drv_b_addr;
  assign fp_if.b_wdata = drv_b_wdata;

  bram_port_arbiter #(
    .DATA_WIDTH(8), .ADDR_WIDTH(10), .PRIORITY_MODE(0), .STARVE_LIMIT(4)
  ) u_rr (
    .clk(clk), .rst(rst), .halt(halt), .idle(rr_idle), .bus_io(rr_if)
  );

  bram_port_arbiter #(
    .DATA_WIDTH(8), .ADDR_WIDTH(10), .PRIORITY_MODE(1), .STARVE_LIMIT(4)
  ) u_fp (
    .clk(clk), .rst(rst), .halt(halt), .idle(fp_idle), .bus_io(fp_if)
  );

  // Single-port BRAM models with 1-cycle registered read
  logic [7:0] mem_rr [1024];
  logic [7:0] mem_fp [1024];
  logic [7:0] rr_rd_q;
  logic [7:0] fp_rd_q;

  always_ff @(posedge clk) begin
    if (rr_if.bram_wr_en) mem_rr[rr_if.bram_addr] <= rr_if.bram_wr_data;
    if (rr_if.bram_rd_en) rr_rd_q <= mem_rr[rr_if.bram_addr];
    if (fp_if.bram_wr_en) mem_fp[fp_if.bram_addr] <= fp_if.bram_wr_data;
    if (fp_if.bram_rd_en) fp_rd_q <= mem_fp[fp_if.bram_addr];
  end

  assign rr_if.bram_rd_data = rr_rd_q;
  assign fp_if.bram_rd_data = fp_rd_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic any_act;

  initial begin
    halt        = 1'b0;
    drv_a_valid = 1'b0;
    drv_a_we    = 1'b0;
    drv_a_addr  = '0;
    drv_a_wdata = '0;
    drv_b_valid = 1'b0;
    drv_b_we    = 1'b0;
    drv_b_addr  = '0;
    drv_b_wdata = '0;
    #1 rst = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(rr_if.bram_wr_en), 32'd0);
    chk("rst_rd_en", 32'(rr_if.bram_rd_en), 32'd0);
    chk("rst_addr", 32'(rr_if.bram_addr), 32'd0);
    chk("rst_wr_data", 32'(rr_if.bram_wr_data), 32'd0);
    chk("rst_a_rvalid", 32'(rr_if.a_rvalid), 32'd0);
    chk("rst_b_rvalid", 32'(rr_if.b_rvalid), 32'd0);
    chk("rst_a_rdata", 32'(rr_if.a_rdata), 32'd0);
    chk("rst_idle", 32'(rr_idle), 32'd0);
    halt = 1'b1;
    #1 chk("rst_idle_halt", 32'(rr_idle), 32'd0);
    halt = 1'b0;
    tick();
    rst = 1'b1;

    // Quiet after reset release
    any_act = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      any_act = any_act | rr_if.bram_wr_en | rr_if.bram_rd_en | rr_if.a_rvalid
              | rr_if.b_rvalid | rr_if.a_ready | rr_if.b_ready;
    end
    chk("quiet_after_reset", 32'(any_act), 32'd0);
    chk("idle_no_halt", 32'(rr_idle), 32'd0);
    halt = 1'b1;
    #1 chk("idle_halt", 32'(rr_idle), 32'd1);
    halt = 1'b0;

    // A writes 0x5A @ 0x003, then reads it back
    tick();
    drv_a_valid = 1'b1; drv_a_we = 1'b1; drv_a_addr = 10'h003; drv_a_wdata = 8'h5A;
    #1;
    chk("wr_a_ready", 32'(rr_if.a_ready), 32'd1);
    chk("wr_b_ready", 32'(rr_if.b_ready), 32'd0);
    tick();
    drv_a_we = 1'b0;
    #1;
    chk("wr_issue_en", 32'(rr_if.bram_wr_en), 32'd1);
    chk("wr_issue_rd_en", 32'(rr_if.bram_rd_en), 32'd0);
    chk("wr_issue_addr", 32'(rr_if.bram_addr), 32'h003);
    chk("wr_issue_data", 32'(rr_if.bram_wr_data), 32'h5A);
    chk("rd_a_ready", 32'(rr_if.a_ready), 32'd1);
    tick();
    drv_a_valid = 1'b0;
    #1;
    chk("rd_issue_en", 32'(rr_if.bram_rd_en), 32'd1);
    chk("rd_issue_wr_en", 32'(rr_if.bram_wr_en), 32'd0);
    chk("rd_issue_addr", 32'(rr_if.bram_addr), 32'h003);
    chk("rd_n1_rvalid", 32'(rr_if.a_rvalid), 32'd0);
    tick();
    #1;
    chk("rd_n2_a_rvalid", 32'(rr_if.a_rvalid), 32'd1);
    chk("rd_n2_a_rdata", 32'(rr_if.a_rdata), 32'h5A);
    chk("rd_n2_b_rvalid", 32'(rr_if.b_rvalid), 32'd0);
    chk("rd_n2_rd_en", 32'(rr_if.bram_rd_en), 32'd0);
    tick();
    #1;
    chk("rd_n3_a_rvalid", 32'(rr_if.a_rvalid), 32'd0);
    chk("rd_n3_hold", 32'(rr_if.a_rdata), 32'h5A);

    // Preload 0x010 = 0x11 (A) and 0x020 = 0x22 (B); last grant B leaves pointer at A
    tick();
    drv_a_valid = 1'b1; drv_a_we = 1'b1; drv_a_addr = 10'h010; drv_a_wdata = 8'h11;
    tick();
    drv_a_valid = 1'b0;
    drv_b_valid = 1'b1; drv_b_we = 1'b1; drv_b_addr = 10'h020; drv_b_wdata = 8'h22;
    tick();
    drv_b_valid = 1'b0;
    tick();

    // Both continuously reading: rr alternates A,B; fixed mode gives A,A,A,A,B
    drv_a_valid = 1'b1; drv_a_we = 1'b0; drv_a_addr = 10'h010;
    drv_b_valid = 1'b1; drv_b_we = 1'b0; drv_b_addr = 10'h020;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) tick();
      #1;
      chk($sformatf("rr_a_ready[%0d]", i), 32'(rr_if.a_ready), 32'(i % 2 == 0));
      chk($sformatf("rr_b_ready[%0d]", i), 32'(rr_if.b_ready), 32'(i % 2 == 1));
      chk($sformatf("fp_a_ready[%0d]", i), 32'(fp_if.a_ready), 32'(i % 5 != 4));
      chk($sformatf("fp_b_ready[%0d]", i), 32'(fp_if.b_ready), 32'(i % 5 == 4));
      if (i >= 2) begin
        chk($sformatf("rr_a_rvalid[%0d]", i), 32'(rr_if.a_rvalid), 32'(i % 2 == 0));
        chk($sformatf("rr_b_rvalid[%0d]", i), 32'(rr_if.b_rvalid), 32'(i % 2 == 1));
        if (i % 2 == 0) chk($sformatf("rr_a_rdata[%0d]", i), 32'(rr_if.a_rdata), 32'h11);
        else            chk($sformatf("rr_b_rdata[%0d]", i), 32'(rr_if.b_rdata), 32'h22);
      end
    end
    tick();
    drv_a_valid = 1'b0;
    drv_b_valid = 1'b0;
    repeat (3) tick();

    // Streaming writes from B with halt raised mid-stream
    for (int k = 0; k < 3; k++) begin
      tick();
      drv_b_valid = 1'b1; drv_b_we = 1'b1;
      drv_b_addr = 10'(10'h100 + k); drv_b_wdata = 8'(k);
      #1 chk($sformatf("stream_ready[%0d]", k), 32'(rr_if.b_ready), 32'd1);
    end
    tick();
    drv_b_addr = 10'h103; drv_b_wdata = 8'h03; halt = 1'b1;
    #1;
    chk("halt_b_ready", 32'(rr_if.b_ready), 32'd0);
    chk("halt_last_wr_en", 32'(rr_if.bram_wr_en), 32'd1);
    chk("halt_last_addr", 32'(rr_if.bram_addr), 32'h102);
    chk("halt_idle_busy", 32'(rr_idle), 32'd0);
    tick();
    #1;
    chk("halt_idle", 32'(rr_idle), 32'd1);
    chk("halt_no_wr", 32'(rr_if.bram_wr_en), 32'd0);
    tick();
    halt = 1'b0;
    #1;
    chk("resume_b_ready", 32'(rr_if.b_ready), 32'd1);
    chk("resume_idle", 32'(rr_idle), 32'd0);
    tick();
    drv_b_valid = 1'b0;
    #1;
    chk("resume_wr_en", 32'(rr_if.bram_wr_en), 32'd1);
    chk("resume_addr", 32'(rr_if.bram_addr), 32'h103);
    chk("resume_data", 32'(rr_if.bram_wr_data), 32'h03);
    tick();
    drv_a_valid = 1'b1; drv_a_we = 1'b0; drv_a_addr = 10'h102;
    tick();
    drv_a_addr = 10'h103;
    tick();
    drv_a_valid = 1'b0;
    #1;
    chk("readback_102_rvalid", 32'(rr_if.a_rvalid), 32'd1);
    chk("readback_102_data", 32'(rr_if.a_rdata), 32'h02);
    tick();
    #1;
    chk("readback_103_rvalid", 32'(rr_if.a_rvalid), 32'd1);
    chk("readback_103_data", 32'(rr_if.a_rdata), 32'h03);

    // Reset pulsed while a read is in flight
    tick();
    drv_a_valid = 1'b1; drv_a_we = 1'b0; drv_a_addr = 10'h010;
    #1 chk("inflight_a_ready", 32'(rr_if.a_ready), 32'd1);
    tick();
    drv_a_valid = 1'b0;
    #1 chk("inflight_rd_en", 32'(rr_if.bram_rd_en), 32'd1);
    rst = 1'b0;
    #1;
    chk("midrst_rd_en", 32'(rr_if.bram_rd_en), 32'd0);
    chk("midrst_addr", 32'(rr_if.bram_addr), 32'd0);
    chk("midrst_a_rvalid", 32'(rr_if.a_rvalid), 32'd0);
    chk("midrst_a_rdata", 32'(rr_if.a_rdata), 32'd0);
    chk("midrst_b_rdata", 32'(rr_if.b_rdata), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    any_act = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      any_act = any_act | rr_if.a_rvalid | rr_if.b_rvalid | rr_if.bram_rd_en
              | rr_if.bram_wr_en;
    end
    chk("post_rst_no_rvalid", 32'(any_act), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
